// File: rtl/apb_reg_slave.sv
// APB3 completer: a word-aligned bank of 32-bit registers with fixed wait states.
// reg[0] is a read-only ID. Errors flag misaligned, out-of-window and read-only writes.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned CNT_W  = 4;
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * NUM_REGS);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic                write_q,   write_d;
    logic                pready_q,  pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q,  prdata_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic                setup_c;
    logic [ADDR_W-1:0]   dec_addr_c;
    logic                dec_write_c;
    logic [ADDR_W-1:0]   offset_c;
    logic [IDX_W-1:0]    idx_c;
    logic                dec_err_c;
    logic [DATA_W-1:0]   rd_val_c;

    // Decode the bus address at the setup edge, the latched copy during ACCESS
    always_comb begin
        setup_c     = (state_q == S_IDLE) && psel && !penable;
        dec_addr_c  = setup_c ? paddr  : addr_q;
        dec_write_c = setup_c ? pwrite : write_q;
        offset_c    = dec_addr_c - BASE_ADDR;
        idx_c       = offset_c[IDX_W+1:2];
        dec_err_c   = (dec_addr_c[1:0] != 2'b00)
                   || (dec_addr_c < BASE_ADDR)
                   || (offset_c >= SPAN)
                   || (dec_write_c && (idx_c == '0));
        rd_val_c    = (idx_c == '0) ? ID_VALUE : regs_q[idx_c];
    end

    // Next-state, register bank update and one-edge-early response
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        regs_d    = regs_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    state_d = S_ACCESS;
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = dec_err_c;
                        prdata_d  = (dec_err_c || dec_write_c) ? '0 : rd_val_c;
                    end
                end
            end
            S_ACCESS: begin
                if (!(psel && penable)) begin
                    // Abort: drop the transfer and return to idle quietly
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        pready_d  = 1'b1;
                        pslverr_d = dec_err_c;
                        prdata_d  = (dec_err_c || dec_write_c) ? '0 : rd_val_c;
                    end
                end else begin
                    // Completing cycle: pready is high now
                    if (write_q && !dec_err_c) begin
                        regs_d[idx_c] = wdata_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; synchronous reset wins over everything
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule
